memtest_pll_reconfig: RTL and testbench

Sequencer that retunes the memory-test SDRAM clock PLL. It consumes the frequency index and retune request produced by the memtest control/timer logic. It drives the Avalon-MM management port of the PLL reconfiguration core (`pll_cfg`) with the fixed 8-write programming sequence, then pulses PLL reset and waits for lock. It also supplies the BCD frequency code shown by the video overlay.

---
 rtl/memtest_pkg.sv | 101 ++++++++++
 rtl/memtest_pll_reconfig.sv | 167 ++++++++++++++++
 tb/tb_memtest_pll_reconfig.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memtest_pkg.sv
// memtest_pkg: shared state type, PLL retune table and management
// register map for the memtest SDRAM clock sequencer.
package memtest_pkg;

  localparam int NUM_FREQ = 38;

  localparam logic [5:0] MGMT_MODE  = 6'd0;
  localparam logic [5:0] MGMT_APPLY = 6'd2;
  localparam logic [5:0] MGMT_N     = 6'd3;
  localparam logic [5:0] MGMT_M     = 6'd4;
  localparam logic [5:0] MGMT_C0    = 6'd5;
  localparam logic [5:0] MGMT_K     = 6'd7;
  localparam logic [5:0] MGMT_BW    = 6'd8;
  localparam logic [5:0] MGMT_CP    = 6'd9;

  typedef enum logic [2:0] {
    IDLE, WR, GAPW, PRST, LOCKW, FIN
  } state_t;

  typedef struct packed {
    logic [11:0] freq;
    logic [31:0] m;
    logic [31:0] k;
    logic [31:0] c;
  } pll_cfg_t;

  // VCO = 50 MHz * (M + K/2^32), N bypassed; out = VCO / C
  localparam pll_cfg_t PLL_CFG_TABLE [NUM_FREQ] = '{
    '{12'h167, 32'h00808, 32'hB33332DD, 32'h20302},
    '{12'h165, 32'h00808, 32'h80000000, 32'h20302},
    '{12'h163, 32'h00808, 32'h4CCCCCCD, 32'h20302},
    '{12'h160, 32'h00808, 32'h00000001, 32'h20302},
    '{12'h158, 32'h20807, 32'hCCCCCCCD, 32'h20302},
    '{12'h155, 32'h20807, 32'h80000000, 32'h20302},
    '{12'h153, 32'h20807, 32'h4CCCCCCD, 32'h20302},
    '{12'h150, 32'h20807, 32'h00000001, 32'h20302},
    '{12'h148, 32'h00707, 32'hCCCCCCCD, 32'h20302},
    '{12'h145, 32'h00707, 32'h80000000, 32'h20302},
    '{12'h143, 32'h00707, 32'h4CCCCCCD, 32'h20302},
    '{12'h142, 32'h00707, 32'h33333333, 32'h20302},
    '{12'h140, 32'h00707, 32'h00000001, 32'h20302},
    '{12'h138, 32'h20706, 32'hCCCCCCCD, 32'h20302},
    '{12'h135, 32'h20706, 32'h80000000, 32'h20302},
    '{12'h133, 32'h20706, 32'h4CCCCCCD, 32'h20302},
    '{12'h130, 32'h20706, 32'h00000001, 32'h20302},
    '{12'h128, 32'h00606, 32'hCCCCCCCD, 32'h20302},
    '{12'h125, 32'h00606, 32'h80000000, 32'h20302},
    '{12'h123, 32'h00606, 32'h4CCCCCCD, 32'h20302},
    '{12'h120, 32'h00606, 32'h00000001, 32'h20302},
    '{12'h118, 32'h20605, 32'hCCCCCCCD, 32'h20302},
    '{12'h115, 32'h20605, 32'h80000000, 32'h20302},
    '{12'h113, 32'h20605, 32'h4CCCCCCD, 32'h20302},
    '{12'h110, 32'h20605, 32'h00000001, 32'h20302},
    '{12'h108, 32'h00505, 32'hCCCCCCCD, 32'h20302},
    '{12'h105, 32'h00505, 32'h80000000, 32'h20302},
    '{12'h103, 32'h00505, 32'h4CCCCCCD, 32'h20302},
    '{12'h100, 32'h00505, 32'h00000001, 32'h20302},
    '{12'h098, 32'h20A09, 32'h9999999A, 32'h00505},
    '{12'h095, 32'h20A09, 32'h00000001, 32'h00505},
    '{12'h093, 32'h00909, 32'h9999999A, 32'h00505},
    '{12'h090, 32'h00909, 32'h00000001, 32'h00505},
    '{12'h088, 32'h20908, 32'h9999999A, 32'h00505},
    '{12'h085, 32'h20908, 32'h00000001, 32'h00505},
    '{12'h080, 32'h00808, 32'h00000001, 32'h00505},
    '{12'h075, 32'h20807, 32'h00000001, 32'h00505},
    '{12'h070, 32'h00707, 32'h00000001, 32'h00505}
  };

  function automatic logic [5:0] step_addr(input logic [2:0] s);
    logic [5:0] a;
    case (s)
      3'd0:    a = MGMT_MODE;
      3'd1:    a = MGMT_M;
      3'd2:    a = MGMT_K;
      3'd3:    a = MGMT_N;
      3'd4:    a = MGMT_C0;
      3'd5:    a = MGMT_CP;
      3'd6:    a = MGMT_BW;
      default: a = MGMT_APPLY;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] step_data(
    input logic [2:0] s,
    input pll_cfg_t   cfg
  );
    logic [31:0] d;
    case (s)
      3'd1:    d = cfg.m;
      3'd2:    d = cfg.k;
      3'd3:    d = 32'h0001_0000;
      3'd4:    d = cfg.c;
      3'd5:    d = 32'd1;
      3'd6:    d = 32'd7;
      default: d = 32'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/memtest_pll_reconfig.sv
// memtest_pll_reconfig: programs the SDRAM clock PLL through the
// reconfig core's management port, pulses PLL reset, waits for lock.
module memtest_pll_reconfig
  import memtest_pkg::*;
#(
  parameter int GAP      = 7,
  parameter int RST_LEN  = 8,
  parameter int LOCK_TMO = 1048575
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic        start,
  input  logic [5:0]  sel,
  input  logic        locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        pll_reset,
  output logic        busy,
  output logic        done,
  output logic        lock_err,
  output logic [11:0] freq_code
);

  localparam logic [19:0] GAP_END = 20'(GAP - 1);
  localparam logic [19:0] RST_END = 20'(RST_LEN - 1);
  localparam logic [19:0] TMO_END = 20'(LOCK_TMO - 1);
  localparam logic [19:0] TMO_SAT = 20'(LOCK_TMO);
  localparam logic [5:0]  IDX_MAX = 6'(NUM_FREQ - 1);

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [19:0] cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic        wr_q, wr_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        prst_q, prst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [11:0] fc_q, fc_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    prst_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    // lock seen before/while PLL is reset is stale
    s1_d    = locked & ~prst_q;
    s2_d    = s1_q & ~prst_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = (sel > IDX_MAX) ? IDX_MAX : sel;
          err_d   = 1'b0;
          step_d  = 3'd0;
          busy_d  = 1'b1;
          wr_d    = 1'b1;
          addr_d  = step_addr(3'd0);
          data_d  = step_data(3'd0, PLL_CFG_TABLE[idx_d]);
          state_d = WR;
        end
      end
      WR: begin
        if (!mgmt_waitrequest) begin
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = GAPW;
        end
      end
      GAPW: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (step_q == 3'd7) begin
            prst_d  = 1'b1;
            state_d = PRST;
          end else begin
            step_d  = step_q + 3'd1;
            wr_d    = 1'b1;
            addr_d  = step_addr(step_d);
            data_d  = step_data(step_d, PLL_CFG_TABLE[idx_q]);
            state_d = WR;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      PRST: begin
        if (cnt_q == RST_END) begin
          cnt_d   = '0;
          state_d = LOCKW;
        end else begin
          prst_d = 1'b1;
          cnt_d  = cnt_q + 20'd1;
        end
      end
      LOCKW: begin
        if (s2_q || cnt_q == TMO_END) begin
          err_d   = ~s2_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIN;
        end else if (cnt_q != TMO_SAT) begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fc_d = PLL_CFG_TABLE[idx_d].freq;
  end

  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      prst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fc_q    <= PLL_CFG_TABLE[0].freq;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      prst_q  <= prst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  assign mgmt_write     = wr_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = data_q;
  assign pll_reset      = prst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign lock_err       = err_q;
  assign freq_code      = fc_q;

endmodule

// File: tb/tb_memtest_pll_reconfig.sv
// tb_memtest_pll_reconfig: directed and randomized retune sequences
// checked against a cycle-count model of the programming sequence.
module tb_memtest_pll_reconfig;

  localparam int GAP    = 7;
  localparam int RSTL   = 8;
  localparam int TMO    = 300;
  localparam int BUDGET = 2000;

  logic        CLK_50M = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  sel = '0;
  logic        locked = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        pll_reset;
  logic        busy;
  logic        done;
  logic        lock_err;
  logic [11:0] freq_code;

  memtest_pll_reconfig #(
    .GAP(GAP), .RST_LEN(RSTL), .LOCK_TMO(TMO)
  ) dut (
    .CLK_50M(CLK_50M), .RESET(RESET), .start(start), .sel(sel),
    .locked(locked), .mgmt_waitrequest(mgmt_waitrequest),
    .mgmt_write(mgmt_write), .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata), .pll_reset(pll_reset),
    .busy(busy), .done(done), .lock_err(lock_err),
    .freq_code(freq_code)
  );

  initial forever #10 CLK_50M = ~CLK_50M;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
    int          t;
  } wr_t;

  wr_t wq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc_n, prst_first, prst_cnt, done_cyc, done_cnt;
  int  hold_cnt, stall_step, stall_left;
  bit  hold_bad, rst_hit, timed_out;
  logic [5:0]  hold_a;
  logic [31:0] hold_d;
  logic busy1, wr1, err1, err_at_done, end_busy, end_err;
  logic wr_rst, busy_rst, err_rst;
  logic [11:0] fc1, end_fc, fc_rst;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rows whose contents are fixed independently of the frequency plan
  function automatic bit known_row(input int i, output logic [11:0] f,
      output logic [31:0] m, output logic [31:0] k,
      output logic [31:0] c);
    bit kn = 1'b1;
    f = '0; m = '0; k = '0; c = '0;
    if (i == 0) begin
      f = 12'h167; m = 32'h808; k = 32'hB33332DD; c = 32'h20302;
    end else if (i == 12) begin
      f = 12'h140; m = 32'h707; k = 32'd1; c = 32'h20302;
    end else if (i == 37) begin
      f = 12'h070; m = 32'h707; k = 32'd1; c = 32'h505;
    end else kn = 1'b0;
    return kn;
  endfunction

  function automatic int exp_addr(input int i);
    int tbl[8] = '{0, 4, 7, 3, 5, 9, 8, 2};
    return tbl[i];
  endfunction

  function automatic logic [31:0] exp_data(input int i,
      input logic [31:0] m, input logic [31:0] k, input logic [31:0] c);
    logic [31:0] d;
    case (i)
      1: d = m;
      2: d = k;
      3: d = 32'h10000;
      4: d = c;
      5: d = 32'd1;
      6: d = 32'd7;
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  task automatic tick();
    if (!RESET) begin
      if (mgmt_write && wq.size() == stall_step) begin
        if (hold_cnt == 0) begin
          hold_a = mgmt_address;
          hold_d = mgmt_writedata;
        end else if (hold_a !== mgmt_address || hold_d !== mgmt_writedata)
          hold_bad = 1'b1;
        hold_cnt++;
      end
      if (mgmt_write && !mgmt_waitrequest)
        wq.push_back('{mgmt_address, mgmt_writedata, cyc_n});
      if (pll_reset) begin
        if (prst_cnt == 0) prst_first = cyc_n;
        prst_cnt++;
      end
      if (done) begin
        if (done_cnt == 0) begin
          done_cyc = cyc_n;
          err_at_done = lock_err;
        end
        done_cnt++;
      end
    end
    @(posedge CLK_50M);
    #1;
    cyc_n++;
    mgmt_waitrequest = 1'b0;
    if (mgmt_write && wq.size() == stall_step && stall_left > 0) begin
      mgmt_waitrequest = 1'b1;
      stall_left--;
    end
  endtask

  task automatic run(input logic [5:0] s, input int ws, input int wl,
      input logic lk, input int g_at, input logic [5:0] g_sel,
      input int r_at);
    wq.delete();
    prst_first = -1; prst_cnt = 0; done_cyc = -1; done_cnt = 0;
    hold_cnt = 0; hold_bad = 0; err_at_done = 0;
    stall_step = ws; stall_left = wl; rst_hit = 0;
    cyc_n = 0; sel = s; locked = lk; start = 1'b1;
    mgmt_waitrequest = 1'b0;
    tick();
    start = 1'b0;
    busy1 = busy; wr1 = mgmt_write; err1 = lock_err; fc1 = freq_code;
    for (int i = 0; i < BUDGET; i++) begin
      start = (cyc_n == g_at);
      sel = (cyc_n == g_at) ? g_sel : s;
      if (cyc_n == r_at) begin
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        wr_rst = mgmt_write; busy_rst = busy;
        err_rst = lock_err; fc_rst = freq_code;
        rst_hit = 1'b1;
        break;
      end
      if (done_cnt > 0 && cyc_n > done_cyc + 1) break;
      tick();
    end
    start = 1'b0;
    timed_out = !rst_hit && done_cnt == 0;
    end_busy = busy; end_err = lock_err; end_fc = freq_code;
  endtask

  task automatic check_run(input string nm, input logic [5:0] s,
      input int ws, input int wl, input logic lk);
    int idx, t, acc, lockw, exp_done;
    bit kn;
    logic [11:0] f;
    logic [31:0] m, k, c;
    idx = (s > 37) ? 37 : int'(s);
    kn = known_row(idx, f, m, k, c);
    chk($sformatf("%s/timeout", nm), timed_out, 0);
    chk($sformatf("%s/busy1", nm), busy1, 1);
    chk($sformatf("%s/wr1", nm), wr1, 1);
    chk($sformatf("%s/err1", nm), err1, 0);
    chk($sformatf("%s/nwr", nm), wq.size(), 8);
    t = 1;
    for (int i = 0; i < 8; i++) begin
      acc = t + ((i == ws) ? wl : 0);
      if (i < wq.size()) begin
        chk($sformatf("%s/a%0d", nm, i), wq[i].a, exp_addr(i));
        chk($sformatf("%s/t%0d", nm, i), wq[i].t, acc);
        if (kn || !(i inside {1, 2, 4}))
          chk($sformatf("%s/d%0d", nm, i), wq[i].d, exp_data(i, m, k, c));
      end
      t = acc + 1 + GAP;
    end
    chk($sformatf("%s/prst0", nm), prst_first, t);
    chk($sformatf("%s/prstn", nm), prst_cnt, RSTL);
    lockw = t + RSTL;
    exp_done = lk ? lockw + 3 : lockw + TMO;
    chk($sformatf("%s/donet", nm), done_cyc, exp_done);
    chk($sformatf("%s/donen", nm), done_cnt, 1);
    chk($sformatf("%s/errd", nm), err_at_done, !lk);
    chk($sformatf("%s/errend", nm), end_err, !lk);
    chk($sformatf("%s/busyend", nm), end_busy, 0);
    if (kn) begin
      chk($sformatf("%s/fc1", nm), fc1, f);
      chk($sformatf("%s/fcend", nm), end_fc, f);
    end
    if (ws >= 0) begin
      chk($sformatf("%s/hold", nm), hold_cnt, wl + 1);
      chk($sformatf("%s/stable", nm), hold_bad, 0);
    end
  endtask

  initial begin
    logic [5:0] rs;
    int rws, rwl;
    RESET = 1'b1;
    repeat (3) @(posedge CLK_50M);
    #1;
    chk("rst/wr", mgmt_write, 0);
    chk("rst/addr", mgmt_address, 0);
    chk("rst/data", mgmt_writedata, 0);
    chk("rst/prst", pll_reset, 0);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/err", lock_err, 0);
    chk("rst/fc", freq_code, 12'h167);
    RESET = 1'b0;
    @(posedge CLK_50M);
    #1;

    run(6'd0, -1, 0, 1'b1, -1, 6'd0, -1);
    check_run("sel0", 6'd0, -1, 0, 1'b1);

    rs = 6'($urandom_range(38, 63));
    run(rs, -1, 0, 1'b1, -1, 6'd0, -1);
    check_run("clamp", rs, -1, 0, 1'b1);

    run(6'd12, 2, 5, 1'b1, -1, 6'd0, -1);
    check_run("stall", 6'd12, 2, 5, 1'b1);

    for (int r = 0; r < 3; r++) begin
      rs = 6'($urandom_range(0, 63));
      rws = $urandom_range(0, 7);
      rwl = $urandom_range(1, 6);
      run(rs, rws, rwl, 1'b1, -1, 6'd0, -1);
      check_run($sformatf("rnd%0d", r), rs, rws, rwl, 1'b1);
    end

    run(6'd0, -1, 0, 1'b0, -1, 6'd0, -1);
    check_run("tmo", 6'd0, -1, 0, 1'b0);
    repeat (4) tick();
    chk("tmo/sticky", lock_err, 1);

    run(6'd37, -1, 0, 1'b1, -1, 6'd0, -1);
    check_run("clr", 6'd37, -1, 0, 1'b1);

    run(6'd0, -1, 0, 1'b1, 20, 6'd37, -1);
    check_run("glitch", 6'd0, -1, 0, 1'b1);

    run(6'd37, -1, 0, 1'b1, -1, 6'd0, 33);
    chk("rst4/hit", rst_hit, 1);
    chk("rst4/wr", wr_rst, 0);
    chk("rst4/busy", busy_rst, 0);
    chk("rst4/err", err_rst, 0);
    chk("rst4/fc", fc_rst, 12'h167);
    chk("rst4/nwr", wq.size(), 4);
    repeat (3) tick();

    run(6'd0, -1, 0, 1'b1, -1, 6'd0, -1);
    check_run("after", 6'd0, -1, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
